// File: rtl/cla_serial_subtractor_pkg.sv
// Shared types, defaults and helpers for the slice-serial subtractor.
package cla_serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned N_DEF = 16;
    localparam int unsigned W_DEF = 4;

    // Ceiling log2, never below 1 so a single-slice index still has a bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/cla_serial_subtractor_cla_slice.sv
// W-bit combinational carry-lookahead adder slice.
module cla_slice
    import cla_serial_subtractor_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   carry;
    logic         prod;

    assign g = x & y;
    assign p = x ^ y;

    // Each carry is a flat sum-of-products of generates, propagates and cin.
    always_comb begin
        carry    = '0;
        prod     = 1'b0;
        carry[0] = cin;
        for (int i = 0; i < int'(W); i++) begin
            for (int j = -1; j <= i; j++) begin
                prod = (j < 0) ? cin : g[j];
                for (int m = j + 1; m <= i; m++) begin
                    prod = prod & p[m];
                end
                carry[i+1] = carry[i+1] | prod;
            end
        end
    end

    assign s    = p ^ carry[W-1:0];
    assign cout = carry[W];

endmodule

// File: rtl/cla_serial_subtractor.sv
// Multi-cycle A - B using one W-bit CLA slice per clock.
module cla_serial_subtractor
    import cla_serial_subtractor_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         borrow,
    output logic         ovf
);

    localparam int unsigned NS = N / W;
    localparam int unsigned KW = clog2_min1(NS);

    state_e         state_q, state_d;
    logic [N-1:0]   op_a_q, op_a_d;
    logic [N-1:0]   op_nb_q, op_nb_d;
    logic [N-1:0]   shadow_q, shadow_d;
    logic [KW-1:0]  k_q, k_d;
    logic           c_q, c_d;
    logic [N-1:0]   d_q, d_d;
    logic           borrow_q, borrow_d;
    logic           ovf_q, ovf_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [W-1:0]   x_slice;
    logic [W-1:0]   y_slice;
    logic [W-1:0]   sum;
    logic           cout;

    assign x_slice = W'(op_a_q >> (W * k_q));
    assign y_slice = W'(op_nb_q >> (W * k_q));

    cla_slice #(.W(W)) u_slice (
        .x    (x_slice),
        .y    (y_slice),
        .cin  (c_q),
        .s    (sum),
        .cout (cout)
    );

    // Next-state, operand latching, slice accumulation and final flag capture.
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_nb_d  = op_nb_q;
        shadow_d = shadow_q;
        k_d      = k_q;
        c_d      = c_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    op_a_d  = a;
                    op_nb_d = ~b;
                    c_d     = 1'b1;
                    k_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int i = 0; i < int'(NS); i++) begin
                    if (k_q == KW'(i)) shadow_d[i*W +: W] = sum;
                end
                c_d = cout;
                if (k_q == KW'(NS - 1)) begin
                    state_d  = DONE;
                    d_d      = shadow_d;
                    borrow_d = ~cout;
                    ovf_d    = (op_a_q[N-1] != ~op_nb_q[N-1]) &&
                               (shadow_d[N-1] != op_a_q[N-1]);
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // All state and outputs registered; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_nb_q  <= '0;
            shadow_q <= '0;
            k_q      <= '0;
            c_q      <= 1'b0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_nb_q  <= op_nb_d;
            shadow_q <= shadow_d;
            k_q      <= k_d;
            c_q      <= c_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign d      = d_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;

endmodule

// File: doc/cla_serial_subtractor.md
Name: cla_serial_subtractor

Overview:
- Multi-cycle two's-complement subtractor: computes D = A − B for an N-bit operand pair.
- Processes one W-bit slice per clock through a single W-bit carry-lookahead slice. This trades latency for area against the flat N-bit CLA adder.
- Sits beside the adder in the arithmetic datapath as its inverse operation.
- Provides a start/busy/done handshake, a borrow flag and a signed-overflow flag.

Parameters:
- N, 16, operand and result width in bits; must be a multiple of W.
- W, 4, slice width in bits processed per cycle; also the width of the CLA sub-module.

Ports:
- clk  in  1  single system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when the block is not busy.
- a  in  N  minuend, sampled on the accepting edge.
- b  in  N  subtrahend, sampled on the accepting edge.
- busy  out  1  high while a subtraction is in progress.
- done  out  1  one-cycle pulse; result valid from this cycle onward.
- d  out  N  difference A − B, modulo 2^N.
- borrow  out  1  unsigned borrow: 1 when A < B unsigned.
- ovf  out  1  signed overflow of A − B.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: state=IDLE, busy=0, done=0, d=0, borrow=0, ovf=0, internal operand/carry/index/shadow registers=0.
- Reset takes effect immediately, including mid-RUN. A partial result is discarded, and d/borrow/ovf read 0 after reset.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Transitions:
  - IDLE→RUN when start=1.
  - RUN→DONE on the edge that processes the last slice.
  - DONE→RUN if start=1, back-to-back accepted; otherwise DONE→IDLE.
- Accept edge (start=1 in IDLE or DONE):
  - Latch a into op_a and ~b into op_nb.
  - Set carry register c=1 (the +1 of two's complement).
  - Set slice index k=0.
- RUN, each edge:
  - Feed slice k of op_a, slice k of op_nb and c into the W-bit CLA.
  - Write the sum into slice k of the shadow result.
  - c ← cout; k ← k+1.
  - On k = N/W−1, go to DONE instead of incrementing.
- Final edge (RUN→DONE) registers the outputs together:
  - d ← shadow result including the last slice.
  - borrow ← ~final cout.
  - ovf ← (a_msb ≠ b_msb) & (d_msb ≠ a_msb), using the latched operands.
- d, borrow and ovf change only on the final edge or reset, and hold stably otherwise, including through IDLE and a following RUN.
- Latency: done is high in the cycle following the N/W-th rising edge after the accepting edge, i.e. N/W+1 edges from accept. For N=16, W=4 that is 5 edges, with busy high for 4 cycles.
- start while busy=1 is ignored (no queueing). a and b may change freely after the accepting edge.
- k wraps never; the index width is clog2(N/W), minimum 1.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default N/W constants;
  - a log2 helper function.
- One sub-module, cla_slice: W-bit combinational carry-lookahead with inputs x, y, cin and outputs s, cout. Uses per-bit generate/propagate and lookahead carry equations, no ripple.
- The top level holds the FSM, operand/shadow registers and flag logic.

Test Plan:
- Reset then a=16'h25CD, b=16'h124E, start pulse → busy 4 cycles, done pulse, d=16'h137F, borrow=0, ovf=0.
- a=16'h1111, b=16'hFF66 → d=16'h11AB, borrow=1, ovf=0. Then a=16'h8940, b=16'h0407 → d=16'h8539, borrow=0, ovf=0.
- a=16'h8000, b=16'h0001 → d=16'h7FFF, borrow=0, ovf=1. a=16'h0000, b=16'h0000 → d=0, borrow=0, ovf=0.
- start held high and a/b toggled every cycle during RUN → only the first operands are used. Back-to-back: start=1 in the DONE cycle with a=16'hB509, b=16'h022A → new RUN with no IDLE cycle, then d=16'hB2DF, ovf=0.
- rst_n pulled low during the 2nd RUN cycle → busy=0, done=0, d=0 immediately. After release, a new subtraction completes correctly with no residual carry.
